// File: rtl/video_frame_scaler.sv
// video_frame_scaler
// Single-clock frame store with an integer upscaler. The source side fills
// one of NUM_BUF frame buffers and publishes a buffer only when it is
// complete. The display side reads the most recently published buffer,
// scales it by SCALE, optionally mirrors it, and maps each pixel through
// a writable palette.
module video_frame_scaler #(
    parameter int                    SRC_W      = 160,
    parameter int                    SRC_H      = 144,
    parameter int                    SCALE      = 3,
    parameter int                    PIX_BITS   = 2,
    parameter int                    COLOR_BITS = 16,
    parameter int                    NUM_BUF    = 3,
    parameter logic [COLOR_BITS-1:0] BORDER     = '0
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  src_valid,
    input  logic                  src_vsync,
    input  logic [PIX_BITS-1:0]   src_pixel,
    input  logic                  de,
    input  logic                  hsync,
    input  logic                  vsync,
    input  logic                  flip_x,
    input  logic                  flip_y,
    input  logic                  pal_we,
    input  logic [PIX_BITS-1:0]   pal_addr,
    input  logic [COLOR_BITS-1:0] pal_data,
    output logic [COLOR_BITS-1:0] color,
    output logic                  color_de,
    output logic                  frame_drop
);

    localparam int FRAME     = SRC_W * SRC_H;
    localparam int MEM_DEPTH = NUM_BUF * FRAME;
    localparam int AW        = $clog2(MEM_DEPTH);
    localparam int WAW       = $clog2(FRAME + 1);
    localparam int BW        = $clog2(NUM_BUF);
    localparam int XW        = $clog2(SRC_W + 1);
    localparam int YW        = $clog2(SRC_H + 1);
    localparam int SW        = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int PAL_N     = 1 << PIX_BITS;

    // Lowest buffer index that is neither a nor b.
    function automatic logic [BW-1:0] pick_free(input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = '0;
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            if (BW'(i) != a && BW'(i) != b) r = BW'(i);
        end
        return r;
    endfunction

    function automatic logic [COLOR_BITS-1:0] pal_default(input int i);
        case (i)
            0:       return COLOR_BITS'(16'hFFFF);
            1:       return COLOR_BITS'(16'hCE79);
            2:       return COLOR_BITS'(16'h632C);
            default: return '0;
        endcase
    endfunction

    logic [PIX_BITS-1:0]   mem [0:MEM_DEPTH-1];
    logic [COLOR_BITS-1:0] palette [0:PAL_N-1];

    logic [WAW-1:0]      wr_addr;
    logic [BW-1:0]       wr_buf, latest, rd_buf;
    logic [BW-1:0]       next_latest, next_rd, next_wr;
    logic                frame_done, publish;
    logic                mem_we;
    logic [AW-1:0]       mem_waddr, rd_addr;

    logic                vsync_d, hsync_d, de_d;
    logic                vs_fall, hs_fall, de_fall;
    logic                flip_x_q, flip_y_q;
    logic [XW-1:0]       x, sx;
    logic [YW-1:0]       y, sy;
    logic [SW-1:0]       x_scale, y_scale;
    logic                in_img;

    logic [PIX_BITS-1:0] ram_q;
    logic                de_p1, in_img_p1;

    assign frame_done = (wr_addr == WAW'(FRAME));
    assign publish    = src_vsync && frame_done;
    assign vs_fall    = vsync_d && !vsync;
    assign hs_fall    = hsync_d && !hsync;
    assign de_fall    = de_d && !de;

    // Buffer rotation: a vsync fall coinciding with a publish reads the new
    // frame, and the next write buffer must avoid whatever will be read.
    assign next_latest = publish ? wr_buf : latest;
    assign next_rd     = vs_fall ? next_latest : rd_buf;
    assign next_wr     = publish ? pick_free(next_rd, wr_buf) : wr_buf;

    // Source write port; a pixel arriving with src_vsync starts the next frame.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        if (src_valid && !rst) begin
            if (src_vsync) begin
                mem_we    = 1'b1;
                mem_waddr = AW'(next_wr) * AW'(FRAME);
            end else if (!frame_done) begin
                mem_we    = 1'b1;
                mem_waddr = AW'(wr_buf) * AW'(FRAME) + AW'(wr_addr);
            end
        end
    end

    // Display read address with optional mirroring.
    always_comb begin
        in_img  = (x < XW'(SRC_W)) && (y < YW'(SRC_H));
        sx      = flip_x_q ? XW'(SRC_W - 1) - x : x;
        sy      = flip_y_q ? YW'(SRC_H - 1) - y : y;
        rd_addr = '0;
        if (in_img) rd_addr = AW'(rd_buf) * AW'(FRAME) + AW'(sy) * AW'(SRC_W) + AW'(sx);
    end

    // Writer: address counter, frame publish and drop detection.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            wr_addr    <= '0;
            wr_buf     <= '0;
            latest     <= BW'(NUM_BUF - 1);
            frame_drop <= 1'b0;
        end else begin
            frame_drop <= src_vsync && !frame_done;
            latest     <= next_latest;
            wr_buf     <= next_wr;
            if (src_vsync)
                wr_addr <= src_valid ? WAW'(1) : '0;
            else if (src_valid && !frame_done)
                wr_addr <= wr_addr + 1'b1;
        end
    end

    // Display timing: edge detects, buffer/flip latch and scaled position.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vsync_d  <= 1'b1;
            hsync_d  <= 1'b1;
            de_d     <= 1'b0;
            rd_buf   <= BW'(NUM_BUF - 1);
            flip_x_q <= 1'b0;
            flip_y_q <= 1'b0;
            x        <= '0;
            y        <= '0;
            x_scale  <= '0;
            y_scale  <= '0;
        end else begin
            vsync_d <= vsync;
            hsync_d <= hsync;
            de_d    <= de;
            rd_buf  <= next_rd;
            if (vs_fall) begin
                flip_x_q <= flip_x;
                flip_y_q <= flip_y;
                x        <= '0;
                y        <= '0;
                x_scale  <= '0;
                y_scale  <= '0;
            end else begin
                if (hs_fall) begin
                    x       <= '0;
                    x_scale <= '0;
                end else if (de) begin
                    if (x_scale == SW'(SCALE - 1)) begin
                        x_scale <= '0;
                        if (x < XW'(SRC_W)) x <= x + 1'b1;
                    end else begin
                        x_scale <= x_scale + 1'b1;
                    end
                end
                if (de_fall) begin
                    if (y_scale == SW'(SCALE - 1)) begin
                        y_scale <= '0;
                        if (y < YW'(SRC_H)) y <= y + 1'b1;
                    end else begin
                        y_scale <= y_scale + 1'b1;
                    end
                end
            end
        end
    end

    // Frame memory: one write port for the source, one read port for display.
    always_ff @(posedge pclk) begin
        if (mem_we) mem[mem_waddr] <= src_pixel;
        ram_q <= mem[rd_addr];
    end

    // Output pipeline: palette lookup or border, plus palette writes.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            de_p1     <= 1'b0;
            in_img_p1 <= 1'b0;
            color     <= '0;
            color_de  <= 1'b0;
            for (int i = 0; i < PAL_N; i++) palette[i] <= pal_default(i);
        end else begin
            de_p1     <= de;
            in_img_p1 <= in_img;
            color_de  <= de_p1;
            if (!de_p1)
                color <= '0;
            else if (in_img_p1)
                color <= palette[ram_q];
            else
                color <= BORDER;
            if (pal_we) palette[pal_addr] <= pal_data;
        end
    end

endmodule

// File: tb/tb_video_frame_scaler.sv
// Scoreboard bench for video_frame_scaler (4x3 source, 2x scale, 3 buffers).
module tb_video_frame_scaler;

    localparam int          W   = 4;
    localparam int          H   = 3;
    localparam int          S   = 2;
    localparam logic [15:0] BRD = 16'hB0B0;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic        src_valid, src_vsync;
    logic [1:0]  src_pixel;
    logic        de, hsync, vsync, flip_x, flip_y;
    logic        pal_we;
    logic [1:0]  pal_addr;
    logic [15:0] pal_data;
    logic [15:0] color;
    logic        color_de, frame_drop;

    video_frame_scaler #(
        .SRC_W(W), .SRC_H(H), .SCALE(S), .PIX_BITS(2),
        .COLOR_BITS(16), .NUM_BUF(3), .BORDER(BRD)
    ) dut (
        .pclk(pclk), .rst(rst),
        .src_valid(src_valid), .src_vsync(src_vsync), .src_pixel(src_pixel),
        .de(de), .hsync(hsync), .vsync(vsync),
        .flip_x(flip_x), .flip_y(flip_y),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .color(color), .color_de(color_de), .frame_drop(frame_drop)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [15:0] c;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          applied = 0;
    int          miscompares = 0;
    int          drop_cycles = 0;
    logic [1:0]  latest_m[W*H];
    logic [1:0]  shown[W*H];
    logic [15:0] pal_m[4];
    bit          fx_m, fy_m;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per color_de cycle, checks value and lag.
    always @(negedge pclk) begin
        if (!rst) begin : mon
            exp_t e;
            if (frame_drop) drop_cycles++;
            if (color_de) begin
                if (q.size() == 0) begin
                    applied++;
                    miscompares++;
                    $display("FAIL unexpected_pixel: got color %h expected no output", color);
                end else begin
                    e = q.pop_front();
                    check("pixel_color", color, e.c);
                    check("pixel_lag", cyc, e.cyc);
                end
            end else begin
                check("idle_color", color, 32'h0);
            end
        end
    end

    task automatic pal_reset();
        pal_m[0] = 16'hFFFF;
        pal_m[1] = 16'hCE79;
        pal_m[2] = 16'h632C;
        pal_m[3] = 16'h0000;
    endtask

    function automatic logic [1:0] pat(input int kind, input int i);
        case (kind)
            0:       return 2'd3;
            1:       return 2'd2;
            2:       return 2'(i % 4);
            3:       return 2'((i % 4 + i / 4) % 4);
            4:       return 2'((3 * i) % 4);
            default: return 2'd1;
        endcase
    endfunction

    function automatic logic [15:0] exp_color(input int l, input int c);
        int x, y, sx, sy;
        x = c / S;
        y = l / S;
        if (x >= W || y >= H) return BRD;
        sx = fx_m ? W - 1 - x : x;
        sy = fy_m ? H - 1 - y : y;
        return pal_m[shown[sy * W + sx]];
    endfunction

    task automatic step();
        @(negedge pclk);
    endtask

    task automatic write_frame(input int n, input int kind);
        for (int i = 0; i < n; i++) begin
            src_valid = 1'b1;
            src_pixel = pat(kind, i);
            step();
        end
        src_valid = 1'b0;
        src_vsync = 1'b1;
        step();
        src_vsync = 1'b0;
        if (n == W * H)
            for (int i = 0; i < W * H; i++) latest_m[i] = pat(kind, i);
    endtask

    // Display frame; flips are inverted right after the vsync fall to prove latching.
    task automatic show(input int lines, input int width, input bit fx, input bit fy, input int pal_col);
        flip_x = fx;
        flip_y = fy;
        vsync  = 1'b0;
        step();
        vsync  = 1'b1;
        flip_x = !fx;
        flip_y = !fy;
        shown  = latest_m;
        fx_m   = fx;
        fy_m   = fy;
        step();
        for (int l = 0; l < lines; l++) begin
            hsync = 1'b0;
            step();
            hsync = 1'b1;
            step();
            for (int c = 0; c < width; c++) begin
                de = 1'b1;
                if (l == 0 && c == pal_col) begin
                    pal_we   = 1'b1;
                    pal_addr = 2'd1;
                    pal_data = 16'hF800;
                    pal_m[1] = 16'hF800;
                end else begin
                    pal_we = 1'b0;
                end
                q.push_back('{c: exp_color(l, c), cyc: cyc + 2});
                step();
            end
            pal_we = 1'b0;
            de     = 1'b0;
            step();
            step();
        end
        flip_x = 1'b0;
        flip_y = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() > 0; k++) step();
        check("drain_empty", q.size(), 32'd0);
        q.delete();
    endtask

    initial begin
        src_valid = 1'b0; src_vsync = 1'b0; src_pixel = '0;
        de = 1'b0; hsync = 1'b1; vsync = 1'b1;
        flip_x = 1'b0; flip_y = 1'b0;
        pal_we = 1'b0; pal_addr = '0; pal_data = '0;
        pal_reset();
        for (int i = 0; i < W * H; i++) latest_m[i] = '0;

        // Reset state
        step();
        step();
        check("rst_color", color, 32'h0);
        check("rst_color_de", color_de, 32'h0);
        check("rst_frame_drop", frame_drop, 32'h0);
        check("rst_wr_buf", dut.wr_buf, 32'd0);
        check("rst_latest", dut.latest, 32'd2);
        check("rst_rd_buf", dut.rd_buf, 32'd2);
        rst = 1'b0;
        step();

        // Frames A, B, C without display vsync: writer alternates 1,0,1 around rd_buf=2
        write_frame(W * H, 0);
        check("wr_buf_after_A", dut.wr_buf, 32'd1);
        check("wr_ne_rd_A", dut.wr_buf == dut.rd_buf, 32'd0);
        write_frame(W * H, 1);
        check("wr_buf_after_B", dut.wr_buf, 32'd0);
        check("wr_ne_rd_B", dut.wr_buf == dut.rd_buf, 32'd0);
        write_frame(W * H, 2);
        check("wr_buf_after_C", dut.wr_buf, 32'd1);
        check("wr_ne_rd_C", dut.wr_buf == dut.rd_buf, 32'd0);
        check("latest_after_C", dut.latest, 32'd0);
        show(6, 8, 1'b0, 1'b0, -1);
        drain();

        // Incomplete frame is dropped; display keeps frame C, with border region
        write_frame(5, 5);
        step();
        check("drop_pulses", drop_cycles, 32'd1);
        check("latest_unchanged", dut.latest, 32'd0);
        show(8, 12, 1'b0, 1'b0, -1);
        drain();

        // Flipped display of a frame with distinct rows
        write_frame(W * H, 3);
        show(6, 8, 1'b1, 1'b1, -1);
        drain();

        // Palette write mid-line
        show(2, 8, 1'b0, 1'b0, 3);
        drain();

        // Async reset during simultaneous writing and display
        vsync = 1'b0;
        step();
        vsync = 1'b1;
        step();
        hsync = 1'b0;
        step();
        hsync = 1'b1;
        shown = latest_m;
        fx_m  = 1'b0;
        fy_m  = 1'b0;
        step();
        for (int c = 0; c < 4; c++) begin
            de        = 1'b1;
            src_valid = 1'b1;
            src_pixel = pat(4, c);
            q.push_back('{c: exp_color(0, c), cyc: cyc + 2});
            step();
        end
        #2 rst = 1'b1;
        #1;
        q.delete();
        check("midrst_color", color, 32'h0);
        check("midrst_color_de", color_de, 32'h0);
        check("midrst_frame_drop", frame_drop, 32'h0);
        de = 1'b0;
        src_valid = 1'b0;
        step();
        step();
        check("midrst_latest", dut.latest, 32'd2);
        check("midrst_wr_buf", dut.wr_buf, 32'd0);
        check("midrst_rd_buf", dut.rd_buf, 32'd2);
        rst = 1'b0;
        pal_reset();
        step();
        step();
        check("no_drop_on_rst", drop_cycles, 32'd1);

        // Fresh frame after reset with default palette
        write_frame(W * H, 4);
        show(6, 8, 1'b0, 1'b0, -1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
